// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundle of the CPU, DMA and memory-side signals of the
// tiny16 main-memory arbiter.
//   cpu_*  : CPU request/qualifiers in, grant and read return out
//   dma_*  : DMA request/qualifiers in, grant and read return out
//   mem_*  : registered memory strobe/we/addr/wdata out, mem_rdata in
// slave  : the arbiter's view
// master : the view of the surrounding system (requesters and memory)
interface mem_arbiter_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_lock;
    logic        cpu_gnt;
    logic        cpu_rvalid;
    logic [15:0] cpu_rdata;

    logic        dma_req;
    logic        dma_we;
    logic [15:0] dma_addr;
    logic [15:0] dma_wdata;
    logic        dma_gnt;
    logic        dma_rvalid;
    logic [15:0] dma_rdata;

    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_lock,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_gnt, dma_rvalid, dma_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_lock,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_gnt, dma_rvalid, dma_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter for the tiny16 single-port main memory.
// The CPU has priority; a saturating starvation counter lets the DMA win
// after STARVE_LIMIT consecutive denied cycles, and the CPU can lock the bus
// across read-modify-write sequences. One transfer per cycle; read data is
// steered back to the requester that issued the read.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous, active-low reset
//   bus  : mem_arbiter_if.slave (CPU/DMA request side and memory side)
// Parameter:
//   STARVE_LIMIT : denied DMA cycles before DMA overrides the CPU (1..15)
module mem_arbiter #(
    parameter int STARVE_LIMIT = 3
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

    lock_state_t state_reg, state_next;
    logic [3:0]  starve_cnt_reg, starve_cnt_next;

    logic cpu_gnt, dma_gnt;
    logic cpu_xfer, dma_xfer;

    logic        mem_en_reg, mem_we_reg;
    logic [15:0] mem_addr_reg, mem_wdata_reg;

    // Read tag pipeline: stage 1 rides with mem_en, stage 2 lines up with
    // the cycle in which the memory's synchronous read data is valid.
    logic rd_cpu_reg, rd_dma_reg;
    logic ret_cpu_reg, ret_dma_reg;

    // Grant selection, lock next-state and starvation counter.
    always_comb begin
        cpu_gnt         = 1'b0;
        dma_gnt         = 1'b0;
        state_next      = state_reg;
        starve_cnt_next = starve_cnt_reg;

        if (rst) begin
            if (state_reg == LOCKED) begin
                cpu_gnt = bus.cpu_req;
            end else if (bus.dma_req && (starve_cnt_reg == LIMIT)) begin
                dma_gnt = 1'b1;
            end else if (bus.cpu_req) begin
                cpu_gnt = 1'b1;
            end else begin
                dma_gnt = bus.dma_req;
            end
        end

        cpu_xfer = bus.cpu_req & cpu_gnt;
        dma_xfer = bus.dma_req & dma_gnt;

        // Only an actual CPU transfer changes the lock; idle CPU cycles
        // leave it held.
        if (cpu_xfer) begin
            state_next = bus.cpu_lock ? LOCKED : UNLOCKED;
        end

        // Counting continues while locked so the override is ready at the
        // first unlocked cycle.
        if (!bus.dma_req || dma_xfer) begin
            starve_cnt_next = 4'd0;
        end else if (starve_cnt_reg < LIMIT) begin
            starve_cnt_next = starve_cnt_reg + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= UNLOCKED;
            starve_cnt_reg <= 4'd0;
            mem_en_reg     <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= 16'd0;
            mem_wdata_reg  <= 16'd0;
            rd_cpu_reg     <= 1'b0;
            rd_dma_reg     <= 1'b0;
            ret_cpu_reg    <= 1'b0;
            ret_dma_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            starve_cnt_reg <= starve_cnt_next;
            mem_en_reg     <= cpu_xfer | dma_xfer;
            if (cpu_xfer) begin
                mem_we_reg    <= bus.cpu_we;
                mem_addr_reg  <= bus.cpu_addr;
                mem_wdata_reg <= bus.cpu_wdata;
            end else if (dma_xfer) begin
                mem_we_reg    <= bus.dma_we;
                mem_addr_reg  <= bus.dma_addr;
                mem_wdata_reg <= bus.dma_wdata;
            end else begin
                // Idle: address/data hold, write enable drops.
                mem_we_reg    <= 1'b0;
            end
            rd_cpu_reg  <= cpu_xfer & ~bus.cpu_we;
            rd_dma_reg  <= dma_xfer & ~bus.dma_we;
            ret_cpu_reg <= rd_cpu_reg;
            ret_dma_reg <= rd_dma_reg;
        end
    end

    assign bus.cpu_gnt    = cpu_gnt;
    assign bus.dma_gnt    = dma_gnt;
    assign bus.mem_en     = mem_en_reg;
    assign bus.mem_we     = mem_we_reg;
    assign bus.mem_addr   = mem_addr_reg;
    assign bus.mem_wdata  = mem_wdata_reg;
    assign bus.cpu_rvalid = ret_cpu_reg;
    assign bus.dma_rvalid = ret_dma_reg;
    assign bus.cpu_rdata  = ret_cpu_reg ? bus.mem_rdata : 16'd0;
    assign bus.dma_rdata  = ret_dma_reg ? bus.mem_rdata : 16'd0;

endmodule
